arb_mux: RTL and testbench
==========================

# arb_mux

Parametrised N-input arbitrating multiplexer with valid/ready handshakes, round-robin fairness, multi-beat packet locking and a registered output stage. It generalises the datapath 4:1 select mux into a shared-resource front end. Typical use: several processor-side requesters (instruction fetch, load/store, debug) sharing one memory or bus port. Data width, requester count and packet locking are parameters.

## Interface
- `WIDTH`, default 32: data beat width in bits.
- `N`, default 4: number of requesters; legal for any N ≥ 2, power of two not required.
- `LOCK`, default 1: 1 holds the grant until a beat with `last` is accepted; 0 re-arbitrates after every beat.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in N: per-requester beat valid.
- `in_data` in N×WIDTH: packed; requester i occupies bits [i*WIDTH +: WIDTH].
- `in_last` in N: per-requester end-of-packet flag.
- `in_ready` in N: beat from requester i is accepted when `in_valid[i] && in_ready[i]`.
- `out_valid` out 1: registered output beat valid.
- `out_data` out WIDTH: registered beat data.
- `out_last` out 1: registered end-of-packet flag.
- `out_src` out $clog2(N): index of the requester that supplied the current output beat.
- `out_ready` in 1: downstream accepts the beat when `out_valid && out_ready`.

## Operation
- State machine `IDLE`/`LOCKED`, plus registers `ptr` (priority pointer, $clog2(N) bits) and `gnt` (held grant index).
- `IDLE`:
  - The winner is the first `i` with `in_valid[i]`, searching `ptr`, `ptr+1`, …, N-1, 0, …, `ptr-1`.
  - Only the winner's `in_ready` may be 1.
  - On acceptance with `in_last=1` or `LOCK=0`: stay `IDLE` and set `ptr` to winner+1 mod N.
  - On acceptance with `in_last=0` and `LOCK=1`: go to `LOCKED` with `gnt` = winner; `ptr` does not change.
- `LOCKED`:
  - Only `in_ready[gnt]` may be 1; other requesters' valids are ignored.
  - On an accepted beat with `in_last=1`: go to `IDLE` and set `ptr` to `gnt`+1 mod N.
  - If `in_valid[gnt]` is low, wait indefinitely with no switch and no timeout.
- Output stage acceptance rule: the stage accepts a new beat when `!out_valid || out_ready`.
  - The granted requester's `in_ready` = stage acceptance condition.
  - On acceptance, `out_data`, `out_last` and `out_src` load from the granted requester and `out_valid` is set to 1.
  - If `out_ready` is high and no input beat is accepted, `out_valid` clears to 0.
- Stall: while `out_valid && !out_ready`, all `in_ready` are 0 and all `out_*` hold their values.
- Pointer wrap: `ptr` = N-1 advances to 0. Explicit compare is required; modulo by bit truncation is wrong for non-power-of-two N.
- Reset (`rst_n` low at a clock edge):
  - `out_valid`, `out_last` = 0; `out_data` = 0; `out_src` = 0; `ptr` = 0; state = `IDLE`.
  - `in_ready` is forced to all 0 while `rst_n` is low.
  - Reset mid-packet drops the lock; no partial-packet recovery.

## Timing
- Latency 1 cycle: input beat accepted at edge k is visible on `out_*` after edge k.
- Throughput: 1 beat/cycle when `out_ready` is held high, including back-to-back packets from different requesters. No idle bubble between grants.
- `in_ready` depends combinationally on `in_valid` (arbitration), `out_valid`, `out_ready`, state and `ptr`; there is no combinational path from `in_data` to outputs.
- `out_*` are driven purely from registers.
- Simultaneous output pop and input push in the same cycle is a legal full-rate transfer.

## Structure
- Shared package `arb_pkg`: `arb_state_t` enum (`ARB_IDLE`, `ARB_LOCKED`) and a function `idx_w(N)` returning max(1, $clog2(N)).
- Sub-module `rr_pick`, combinational: inputs `req[N]` and `ptr`; outputs `any` and `idx`. Implementation is a rotating priority encoder via a double-width request vector. It is reusable for future writeback and forwarding arbitration.
- `arb_mux` holds the FSM, `ptr`/`gnt` registers, the output stage and the data select, indexed by the grant.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with all `in_valid`=1 → `in_ready`=0000, `out_valid`=0, `out_src`=0; first beat after release comes from requester 0.
- Round-robin (N=4): all four requesters send single-beat packets continuously with `out_ready`=1 → `out_src` sequence is 0,1,2,3,0,1…, one beat per cycle.
- Lock: requester 2 sends a 3-beat packet (0xA0, 0xA1, 0xA2 with last) while requester 0 is valid → outputs are A0, A1, A2 from src 2, then src 3 if valid, otherwise 0.
- Backpressure: `out_ready`=0 for 5 cycles mid-packet → `out_data` stable, `in_ready`=0000; on release, no beat is lost or duplicated and order is preserved.
- Non-power-of-two wrap: N=3 with `ptr` at 2 and requesters 0 and 2 valid → requester 2 wins, next `ptr`=0, then requester 0 wins.
- Reset mid-packet: assert `rst_n`=0 during requester 1's second beat → `IDLE`, `ptr`=0, `out_valid`=0; requester 3's new packet is granted immediately after release.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the requester arbitration blocks.
package arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Index width that never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set request at or after ptr, wrapping at N.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] idx
);

    localparam logic [IW:0] N_W = (IW+1)'(N);

    logic [N-1:0] rot;
    logic [IW:0]  off;
    logic [IW:0]  sum;

    always_comb begin
        // Shifting the doubled vector rotates req so ptr lands at bit 0.
        rot = N'({req, req} >> ptr);
        off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) off = k[IW:0];
        end
        sum = {1'b0, ptr} + off;
        if (sum >= N_W) sum = sum - N_W;
        any = |req;
        idx = IW'(sum);
    end

endmodule

// File: rtl/arb_mux.sv
// N-input round-robin arbitrating mux with optional packet locking and a
// registered output beat; valid/ready on both sides.
module arb_mux
    import arb_pkg::*;
#(
    parameter int  WIDTH = 32,
    parameter int  N     = 4,
    parameter int  LOCK  = 1,
    localparam int IW    = idx_w(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_last,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last,
    output logic [IW-1:0]      out_src,
    input  logic               out_ready,
    output arb_state_t         dbg_state
);

    // Handshake: a beat moves when valid && ready on the same rising edge;
    // a producer holds valid and its payload stable until that edge.

    arb_state_t       state, state_d;
    logic [IW-1:0]    ptr, ptr_d;
    logic [IW-1:0]    gnt, gnt_d;
    logic             pick_any;
    logic [IW-1:0]    pick_idx;
    logic             slot;
    logic [IW-1:0]    sel;
    logic [IW-1:0]    sel_next;
    logic             sel_on;
    logic             sel_valid;
    logic             sel_last;
    logic [WIDTH-1:0] sel_data;
    logic             take;

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req (in_valid),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Output register can take a beat when empty or being drained this cycle.
    assign slot = !out_valid || out_ready;

    always_comb begin
        sel       = (state == ARB_LOCKED) ? gnt : pick_idx;
        sel_on    = rst_n && slot && ((state == ARB_LOCKED) || pick_any);
        sel_data  = '0;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        in_ready  = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == IW'(i)) begin
                sel_data    = in_data[i*WIDTH +: WIDTH];
                sel_last    = in_last[i];
                sel_valid   = in_valid[i];
                in_ready[i] = sel_on;
            end
        end
        take     = sel_on && sel_valid;
        // Explicit wrap so non-power-of-two N cycles correctly.
        sel_next = (sel == IW'(N - 1)) ? '0 : sel + IW'(1);
    end

    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        gnt_d   = gnt;
        if (take) begin
            if (sel_last || (LOCK == 0)) begin
                state_d = ARB_IDLE;
                ptr_d   = sel_next;
            end else begin
                state_d = ARB_LOCKED;
                gnt_d   = sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            ptr       <= '0;
            gnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= '0;
        end else begin
            state <= state_d;
            ptr   <= ptr_d;
            gnt   <= gnt_d;
            if (take) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_last  <= sel_last;
                out_src   <= sel;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: random and directed traffic against a packet-level
// round-robin model, with a scoreboard of expected output beats.
module tb_arb_mux;
    import arb_pkg::*;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam int EW = IW + 1 + W;
    localparam int QD = 256;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N-1:0]   in_valid, in_last, in_ready;
    logic [N*W-1:0] in_data;
    logic           out_valid, out_last, out_ready;
    logic [W-1:0]   out_data;
    logic [IW-1:0]  out_src;
    arb_state_t     dbg_state;

    arb_mux #(.WIDTH(W), .N(N), .LOCK(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_ready (out_ready),
        .dbg_state (dbg_state)
    );

    // three-requester instance for the non-power-of-two wrap
    logic [2:0]   v3, l3, r3;
    logic [3*W-1:0] d3;
    logic         ov3, ol3, ordy3;
    logic [W-1:0] od3;
    logic [1:0]   os3;
    arb_state_t   st3;

    arb_mux #(.WIDTH(W), .N(3), .LOCK(1)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v3),
        .in_data   (d3),
        .in_last   (l3),
        .in_ready  (r3),
        .out_valid (ov3),
        .out_data  (od3),
        .out_last  (ol3),
        .out_src   (os3),
        .out_ready (ordy3),
        .dbg_state (st3)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // per-requester beat sources {last, data}
    logic [W:0] src_mem [N][QD];
    int head [N];
    int tail [N];
    int vprob = 100;
    int rprob = 100;
    logic [N-1:0] last_fire;

    // scoreboard
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] log_q[$];
    bit log_on = 1'b0;

    // round-robin directed watch
    bit rr_on = 1'b0;
    int rr_exp = 0;

    function automatic logic [EW-1:0] beat(input int src, input bit last, input logic [W-1:0] data);
        return {IW'(src), last, data};
    endfunction

    // driver tasks
    task automatic add_pkt(input int r, input int len, input logic [W-1:0] base);
        for (int b = 0; b < len; b++) begin
            src_mem[r][tail[r] % QD] = {(b == len - 1), base + W'(b)};
            tail[r]++;
        end
    endtask

    task automatic present();
        for (int r = 0; r < N; r++) begin
            if (!in_valid[r] && head[r] != tail[r] && $urandom_range(99) < vprob) begin
                in_valid[r] = 1'b1;
                {in_last[r], in_data[r*W +: W]} = src_mem[r][head[r] % QD];
            end
        end
    endtask

    task automatic step();
        logic [N-1:0] fire;
        @(negedge clk);
        fire = in_valid & in_ready;
        if (rr_on) begin
            chk("rr_valid", 64'(out_valid), 64'(1));
            chk("rr_src", 64'(out_src), 64'(rr_exp));
            rr_exp = (rr_exp + 1) % N;
        end
        @(posedge clk);
        #1;
        for (int r = 0; r < N; r++) begin
            if (fire[r]) begin
                head[r]++;
                in_valid[r] = 1'b0;
            end
        end
        last_fire = fire;
        present();
        out_ready = ($urandom_range(99) < rprob);
    endtask

    function automatic bit all_idle();
        bit ok = (exp_q.size() == 0) && !out_valid;
        for (int r = 0; r < N; r++) if (head[r] != tail[r]) ok = 1'b0;
        return ok;
    endfunction

    task automatic drain();
        int c = 0;
        vprob = 100;
        rprob = 100;
        while (c < 300 && !all_idle()) begin
            step();
            c++;
        end
        chk("drain_done", 64'(c < 300), 64'(1));
    endtask

    task automatic chk_log(input string name, input int k, input logic [EW-1:0] e);
        chk(name, (k < log_q.size()) ? 64'(log_q[k]) : 64'hDEAD_BEEF, 64'(e));
    endtask

    // reference model: packet-level round robin with an owner held until last
    int m_ptr = 0;
    bit m_locked = 1'b0;
    int m_owner = 0;
    bit m_ov = 1'b0;

    always @(negedge clk) begin
        int win;
        bit free;
        logic [N-1:0] exp_rdy;
        if (!rst_n) begin
            m_ptr = 0;
            m_locked = 1'b0;
            m_owner = 0;
            m_ov = 1'b0;
            exp_q.delete();
            chk("rst_in_ready", 64'(in_ready), 64'(0));
        end else begin
            chk("out_valid", 64'(out_valid), 64'(m_ov));
            free = !m_ov || out_ready;
            win = -1;
            if (m_locked) win = m_owner;
            else begin
                for (int k = 0; k < N; k++) begin
                    if (win < 0 && in_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
                end
            end
            exp_rdy = '0;
            if (free && win >= 0) exp_rdy[win] = 1'b1;
            chk("in_ready", 64'(in_ready), 64'(exp_rdy));
            if (free && win >= 0 && in_valid[win]) begin
                exp_q.push_back(beat(win, in_last[win], in_data[win*W +: W]));
                if (in_last[win]) begin
                    m_locked = 1'b0;
                    m_ptr = (win + 1) % N;
                end else begin
                    m_locked = 1'b1;
                    m_owner = win;
                end
                m_ov = 1'b1;
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
        end
    end

    // monitor: current output beat must match the oldest expected beat
    always @(negedge clk) begin
        logic [EW-1:0] act;
        if (rst_n && out_valid && exp_q.size() != 0) begin
            act = {out_src, out_last, out_data};
            chk("out_beat", 64'(act), 64'(exp_q[0]));
            if (out_ready) begin
                void'(exp_q.pop_front());
                if (log_on) log_q.push_back(act);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        rst_n = 1'b0;
        in_valid = '0;
        in_last = '0;
        in_data = '0;
        out_ready = 1'b0;
        last_fire = '0;
        v3 = '0;
        l3 = '0;
        d3 = '0;
        ordy3 = 1'b1;
        for (int r = 0; r < N; r++) begin
            head[r] = 0;
            tail[r] = 0;
        end

        // reset with every requester valid, then continuous single beats
        for (int k = 0; k < 3; k++)
            for (int r = 0; r < N; r++) add_pkt(r, 1, W'(16 * r + k));
        present();
        repeat (3) step();
        chk("rst_ready", 64'(in_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_src", 64'(out_src), 64'(0));
        chk("rst_state", 64'(dbg_state), 64'(ARB_IDLE));
        rst_n = 1'b1;
        step();
        rr_on = 1'b1;
        rr_exp = 0;
        repeat (12) step();
        rr_on = 1'b0;
        drain();

        // move the pointer to 2, then a locked 3-beat packet from requester 2
        add_pkt(1, 1, 16'h0011);
        present();
        drain();
        log_q.delete();
        log_on = 1'b1;
        add_pkt(2, 3, 16'h00A0);
        add_pkt(0, 1, 16'h00B0);
        add_pkt(3, 1, 16'h00C0);
        present();
        drain();
        chk("lock_cnt", 64'(log_q.size()), 64'(5));
        chk_log("lock_a0", 0, beat(2, 1'b0, 16'h00A0));
        chk_log("lock_a1", 1, beat(2, 1'b0, 16'h00A1));
        chk_log("lock_a2", 2, beat(2, 1'b1, 16'h00A2));
        chk_log("lock_next3", 3, beat(3, 1'b1, 16'h00C0));
        chk_log("lock_next0", 4, beat(0, 1'b1, 16'h00B0));

        // backpressure for five cycles in the middle of a packet
        log_q.delete();
        add_pkt(1, 4, 16'h0D00);
        present();
        step();
        rprob = 0;
        step();
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_ready", 64'(in_ready), 64'(0));
            chk("stall_valid", 64'(out_valid), 64'(1));
            chk("stall_data", 64'(out_data), 64'h0D01);
        end
        out_ready = 1'b1;
        drain();
        chk("bp_cnt", 64'(log_q.size()), 64'(4));
        for (int k = 0; k < 4; k++) chk_log("bp_beat", k, beat(1, k == 3, W'(16'h0D00 + k)));
        log_on = 1'b0;

        // randomized traffic
        vprob = 50;
        rprob = 70;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(2) == 0) begin
                int r = $urandom_range(N - 1);
                if (tail[r] - head[r] < 200) add_pkt(r, $urandom_range(4, 1), W'($urandom));
            end
            step();
        end
        drain();

        // reset while requester 1 is mid-packet
        out_ready = 1'b1;
        add_pkt(1, 3, 16'h0E00);
        present();
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            step();
            if (last_fire[1]) got = 1'b1;
        end
        chk("mrst_first_beat", 64'(got), 64'(1));
        rst_n = 1'b0;
        step();
        step();
        chk("mrst_state", 64'(dbg_state), 64'(ARB_IDLE));
        chk("mrst_out_valid", 64'(out_valid), 64'(0));
        for (int r = 0; r < N; r++) head[r] = tail[r];
        in_valid = '0;
        in_last = '0;
        log_q.delete();
        log_on = 1'b1;
        add_pkt(3, 2, 16'h0F00);
        present();
        rst_n = 1'b1;
        #1;
        chk("mrst_grant", 64'(in_ready), 64'(4'b1000));
        drain();
        chk_log("mrst_beat0", 0, beat(3, 1'b0, 16'h0F00));
        chk_log("mrst_beat1", 1, beat(3, 1'b1, 16'h0F01));
        log_on = 1'b0;

        // three requesters: pointer at 2 wraps to 0
        @(posedge clk);
        #1;
        v3 = 3'b010;
        l3 = 3'b111;
        d3 = {16'h0022, 16'h0011, 16'h0000};
        #1;
        chk("n3_first", 64'(r3), 64'(3'b010));
        @(posedge clk);
        #1;
        v3 = 3'b101;
        #1;
        chk("n3_wrap_grant", 64'(r3), 64'(3'b100));
        chk("n3_src1", 64'(os3), 64'(1));
        @(posedge clk);
        #1;
        v3 = 3'b001;
        #1;
        chk("n3_src2", 64'(os3), 64'(2));
        chk("n3_data2", 64'(od3), 64'h0022);
        chk("n3_next_grant", 64'(r3), 64'(3'b001));
        @(posedge clk);
        #1;
        v3 = 3'b000;
        #1;
        chk("n3_src0", 64'(os3), 64'(0));
        chk("n3_valid0", 64'(ov3), 64'(1));
        chk("n3_state", 64'(st3), 64'(ARB_IDLE));

        // final report
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
